// File: rtl/gray_pkg.sv
// Shared definitions for the Gray LED sequencer: run-mode encodings, the
// sequencer state type and the binary-to-Gray helper.
package gray_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic {
    RUN,
    HOLD_END
  } seq_state_t;

  // Widths up to 32 bits; callers cast the result down to their LED width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_led_sequencer_if.sv
// Control and status bundle between the board top and the Gray LED sequencer.
interface gray_led_sequencer_if #(parameter int N = 8);

  logic         en;
  logic         dir;
  logic [1:0]   mode;
  logic [1:0]   rate;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] leds;
  logic         tick;
  logic         wrap;
  logic         done;

  modport master (
    output en, dir, mode, rate, load, load_val,
    input  leds, tick, wrap, done
  );

  modport slave (
    input  en, dir, mode, rate, load, load_val,
    output leds, tick, wrap, done
  );

endinterface

// File: rtl/rate_tick_gen.sv
// Step-rate divider: fires a one-cycle step every (DIV >> rate) enabled cycles,
// restarting its period on clr or on any change of rate.
module rate_tick_gen #(
  parameter int DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] rate,
  output logic       step
);

  localparam int DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] term;
  logic [1:0]       rate_q;
  logic             rate_chg;

  always_comb begin
    term = DIV_W'(DIV - 1);
    case (rate)
      2'd0: term = DIV_W'(DIV - 1);
      2'd1: term = DIV_W'((DIV >> 1) - 1);
      2'd2: term = DIV_W'((DIV >> 2) - 1);
      2'd3: term = DIV_W'((DIV >> 3) - 1);
    endcase
  end

  assign rate_chg = (rate != rate_q);
  assign step     = en && !clr && !rate_chg && (div_cnt == term);

  // rate_q captures the live rate during reset so release never looks like a rate change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      rate_q  <= rate;
    end else begin
      rate_q <= rate;
      if (clr || rate_chg) begin
        div_cnt <= '0;
      end else if (en) begin
        div_cnt <= (div_cnt == term) ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/gray_led_sequencer.sv
// N-bit Gray-code LED sequencer with selectable rate, direction, parallel load
// and wrap / one-shot / ping-pong run modes.
module gray_led_sequencer
  import gray_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 100000000
) (
  input logic                 clk,
  input logic                 rst,
  gray_led_sequencer_if.slave bus
);

  logic [N-1:0] bin, bin_n;
  logic [N-1:0] leds_q;
  logic [N-1:0] fwd, back, term;
  logic         tick_q, tick_n;
  logic         wrap_q, wrap_n;
  logic         done_q, done_n;
  logic         cur_dir, cur_dir_n;
  logic [1:0]   mode_q, mode_eff;
  logic         mode_chg, run_en, step;
  seq_state_t   state, state_n;

  assign mode_chg = (bus.mode != mode_q);
  assign mode_eff = (bus.mode == 2'b11) ? MODE_WRAP : bus.mode;
  assign run_en   = bus.en && (state == RUN);

  rate_tick_gen #(.DIV(DIV)) u_rate (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (bus.load || mode_chg),
    .rate (bus.rate),
    .step (step)
  );

  // Terminal is all-ones when counting up and zero when counting down.
  assign term = {N{cur_dir}};
  assign fwd  = cur_dir ? bin + N'(1) : bin - N'(1);
  assign back = cur_dir ? bin - N'(1) : bin + N'(1);

  always_comb begin
    bin_n     = bin;
    cur_dir_n = cur_dir;
    done_n    = done_q;
    state_n   = state;
    tick_n    = 1'b0;
    wrap_n    = 1'b0;
    if (bus.load) begin
      bin_n     = bus.load_val;
      cur_dir_n = bus.dir;
      done_n    = 1'b0;
      state_n   = RUN;
    end else if (mode_chg) begin
      cur_dir_n = bus.dir;
      done_n    = 1'b0;
      state_n   = RUN;
    end else if (step) begin
      tick_n = 1'b1;
      bin_n  = fwd;
      case (mode_eff)
        MODE_ONESHOT: begin
          if (fwd == term) begin
            wrap_n  = 1'b1;
            done_n  = 1'b1;
            state_n = HOLD_END;
          end
        end
        MODE_PINGPONG: begin
          // A value loaded at the terminal reverses immediately instead of rolling over.
          if (bin == term) begin
            bin_n     = back;
            cur_dir_n = !cur_dir;
            wrap_n    = 1'b1;
          end else if (fwd == term) begin
            cur_dir_n = !cur_dir;
            wrap_n    = 1'b1;
          end
        end
        default: begin
          wrap_n = (bin == term);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin     <= '0;
      leds_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      cur_dir <= bus.dir;
      mode_q  <= bus.mode;
      state   <= RUN;
    end else begin
      bin     <= bin_n;
      leds_q  <= N'(bin2gray(32'(bin_n)));
      tick_q  <= tick_n;
      wrap_q  <= wrap_n;
      done_q  <= done_n;
      cur_dir <= cur_dir_n;
      mode_q  <= bus.mode;
      state   <= state_n;
    end
  end

  // Pulses are masked while stepping is disabled.
  assign bus.leds = leds_q;
  assign bus.tick = tick_q && bus.en;
  assign bus.wrap = wrap_q && bus.en;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gray_led_sequencer.sv
// Self-checking bench for gray_led_sequencer at N=3, DIV=8: a cycle model of
// the sequencing rules plus directed scenarios with literal expectations.
module tb_gray_led_sequencer;

  localparam int N    = 3;
  localparam int DIV  = 8;
  localparam int MAXV = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  gray_led_sequencer_if #(.N(N)) bus ();

  gray_led_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic i_en, input logic i_dir, input logic [1:0] i_mode,
                               input logic [1:0] i_rate, input logic i_load, input logic [N-1:0] i_val);
    bus.en       = i_en;
    bus.dir      = i_dir;
    bus.mode     = i_mode;
    bus.rate     = i_rate;
    bus.load     = i_load;
    bus.load_val = i_val;
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Behavioural model: count enabled cycles since the period started and
  // apply the mode rules to an integer count whenever a full period elapses.
  int         m_bin, m_elapsed;
  bit         m_up, m_hold, m_done, m_tick, m_wrap;
  logic [1:0] m_rate_prev, m_mode_prev;

  function automatic void modelStep();
    int eff, term_val, nxt;
    eff      = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
    term_val = m_up ? MAXV : 0;
    m_tick   = 1'b1;
    if (eff == 2 && m_bin == term_val) begin
      m_up   = !m_up;
      m_bin  = (m_bin + (m_up ? 1 : MAXV)) & MAXV;
      m_wrap = 1'b1;
      return;
    end
    nxt = (m_bin + (m_up ? 1 : MAXV)) & MAXV;
    if (eff == 0) m_wrap = (m_bin == term_val);
    if (eff == 1 && nxt == term_val) begin
      m_wrap = 1'b1;
      m_done = 1'b1;
      m_hold = 1'b1;
    end
    if (eff == 2 && nxt == term_val) begin
      m_up   = !m_up;
      m_wrap = 1'b1;
    end
    m_bin = nxt;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bin = 0; m_elapsed = 0; m_up = bus.dir; m_hold = 0; m_done = 0;
      m_tick = 0; m_wrap = 0; m_rate_prev = bus.rate; m_mode_prev = bus.mode;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      if (bus.load) begin
        m_bin = int'(bus.load_val); m_elapsed = 0; m_up = bus.dir; m_done = 0; m_hold = 0;
      end else if (bus.mode != m_mode_prev) begin
        m_elapsed = 0; m_up = bus.dir; m_done = 0; m_hold = 0;
      end else if (bus.rate != m_rate_prev) begin
        m_elapsed = 0;
      end else if (bus.en && !m_hold) begin
        m_elapsed++;
        if (m_elapsed == (DIV >> bus.rate)) begin
          m_elapsed = 0;
          modelStep();
        end
      end
      m_rate_prev = bus.rate;
      m_mode_prev = bus.mode;
    end
  end

  always @(negedge clk) begin
    #1;
    checkOutput("cyc_leds", 32'(bus.leds), 32'(gray(m_bin)));
    checkOutput("cyc_tick", 32'(bus.tick), 32'(m_tick && bus.en));
    checkOutput("cyc_wrap", 32'(bus.wrap), 32'(m_wrap && bus.en));
    checkOutput("cyc_done", 32'(bus.done), 32'(m_done));
  end

  logic [N-1:0] seen_leds[$];
  logic         seen_wrap[$];

  task automatic recordTicks(input int cycles);
    seen_leds.delete();
    seen_wrap.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tick) begin
        seen_leds.push_back(bus.leds);
        seen_wrap.push_back(bus.wrap);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] exp_wrap_seq [8];
    logic [N-1:0] exp_pp_seq [3];
    exp_wrap_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    exp_pp_seq   = '{3'b100, 3'b101, 3'b111};

    applyStimulus(1'b0, 1'b1, 2'b00, 2'd2, 1'b0, 3'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_leds", 32'(bus.leds), 32'd0);
    checkOutput("reset_tick", 32'(bus.tick), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);

    $display("[TB] wrap mode, up, period 2");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'd2, 1'b0, 3'd0);
    recordTicks(16);
    checkOutput("wrap_tick_count", 32'(seen_leds.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("wrap_step%0d_leds", i), 32'(seen_leds[i]), 32'(exp_wrap_seq[i]));
      checkOutput($sformatf("wrap_step%0d_wrap", i), 32'(seen_wrap[i]), 32'(i == 7));
    end

    $display("[TB] one-shot, down from 2");
    applyStimulus(1'b1, 1'b0, 2'b01, 2'd2, 1'b1, 3'd2);
    @(negedge clk);
    checkOutput("os_load_leds", 32'(bus.leds), 32'b011);
    checkOutput("os_load_tick", 32'(bus.tick), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b01, 2'd2, 1'b0, 3'd2);
    recordTicks(30);
    checkOutput("os_tick_count", 32'(seen_leds.size()), 32'd2);
    checkOutput("os_step0_leds", 32'(seen_leds[0]), 32'b001);
    checkOutput("os_step1_leds", 32'(seen_leds[1]), 32'b000);
    checkOutput("os_step0_wrap", 32'(seen_wrap[0]), 32'd0);
    checkOutput("os_step1_wrap", 32'(seen_wrap[1]), 32'd1);
    checkOutput("os_done", 32'(bus.done), 32'd1);
    checkOutput("os_final_leds", 32'(bus.leds), 32'b000);

    $display("[TB] ping-pong, up from 6, period 1");
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd3, 1'b1, 3'd6);
    @(negedge clk);
    checkOutput("pp_load_leds", 32'(bus.leds), 32'b101);
    checkOutput("pp_load_done", 32'(bus.done), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd3, 1'b0, 3'd6);
    recordTicks(3);
    checkOutput("pp_tick_count", 32'(seen_leds.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("pp_step%0d_leds", i), 32'(seen_leds[i]), 32'(exp_pp_seq[i]));
      checkOutput($sformatf("pp_step%0d_wrap", i), 32'(seen_wrap[i]), 32'(i == 0));
    end

    $display("[TB] enable drop mid-period, period 8");
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 2'b10, 2'd0, 1'b0, 3'd0);
    repeat (10) @(negedge clk);
    checkOutput("endrop_frozen_leds", 32'(bus.leds), 32'b111);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("endrop_resume1_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    checkOutput("endrop_resume2_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    checkOutput("endrop_resume3_tick", 32'(bus.tick), 32'd1);
    checkOutput("endrop_resume3_leds", 32'(bus.leds), 32'b110);

    $display("[TB] load coincident with step");
    repeat (7) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 3'd3);
    @(negedge clk);
    checkOutput("ldstep_leds", 32'(bus.leds), 32'b010);
    checkOutput("ldstep_tick", 32'(bus.tick), 32'd0);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd0, 1'b0, 3'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ldstep_wait%0d_tick", i), 32'(bus.tick), 32'd0);
    end
    @(negedge clk);
    checkOutput("ldstep_next_tick", 32'(bus.tick), 32'd1);
    checkOutput("ldstep_next_leds", 32'(bus.leds), 32'b110);

    $display("[TB] asynchronous reset mid-period, period 4");
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd1, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_leds", 32'(bus.leds), 32'd0);
    checkOutput("arst_tick", 32'(bus.tick), 32'd0);
    checkOutput("arst_wrap", 32'(bus.wrap), 32'd0);
    checkOutput("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("arst_wait%0d_tick", i), 32'(bus.tick), 32'd0);
    end
    @(negedge clk);
    checkOutput("arst_first_tick", 32'(bus.tick), 32'd1);
    checkOutput("arst_first_leds", 32'(bus.leds), 32'b001);

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
